// File: rtl/ext_bus_target.sv
// Far-end responder for the external bus: synchronises asynchronous strobes,
// serves a small register bank on one chip select and reports committed writes.
module ext_bus_target #(
  parameter int          CE_INDEX  = 1,
  parameter int          ADDR_BITS = 4,
  parameter logic [31:0] ID_VALUE  = 32'h6769_7001
) (
  input  logic                 int_logic_drm_clock_buffered,
  input  logic                 system_reset,
  input  logic [3:0]           eb_ce_n,
  input  logic                 eb_oe_n,
  input  logic                 eb_we_n,
  input  logic [23:0]          eb_address,
  input  logic [31:0]          eb_data_in,
  output logic [31:0]          eb_data_out,
  output logic                 eb_data_oe,
  input  logic [ADDR_BITS-1:0] int_read_address,
  output logic [31:0]          int_read_data,
  output logic                 wr_pulse,
  output logic [ADDR_BITS-1:0] wr_address,
  output logic [31:0]          wr_data,
  output logic [7:0]           protocol_errors
);

  localparam int WORDS = 1 << ADDR_BITS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  logic [1:0]           r_ce_sync, r_oe_sync, r_we_sync;
  logic [ADDR_BITS-1:0] r_addr_s1, r_addr_s2;
  logic [31:0]          r_data_s1, r_data_s2;

  logic [1:0]           r_state;
  logic [ADDR_BITS-1:0] r_pend_addr;
  logic [31:0]          r_pend_data;
  logic [31:0]          r_bank [WORDS];
  logic [31:0]          r_data_out;
  logic                 r_data_oe;
  logic                 r_wr_pulse;
  logic [ADDR_BITS-1:0] r_wr_address;
  logic [31:0]          r_wr_data;
  logic [7:0]           r_perr;

  logic                 w_s_ce, w_s_oe, w_s_we;
  logic [31:0]          w_bus_rdata;
  logic                 w_commit;
  logic                 w_err_event;
  logic                 w_unused_bits;

  // Byte-lane bits, upper address bits and the other chip selects are don't-care.
  assign w_unused_bits = ^{eb_address[23:ADDR_BITS+2], eb_address[1:0], eb_ce_n};

  assign w_s_ce = r_ce_sync[1];
  assign w_s_oe = r_oe_sync[1];
  assign w_s_we = r_we_sync[1];

  // Address/data take the same two-flop path as the strobes so they stay aligned.
  always_ff @(posedge int_logic_drm_clock_buffered or posedge system_reset) begin
    if (system_reset) begin
      r_ce_sync <= '0;
      r_oe_sync <= '0;
      r_we_sync <= '0;
      r_addr_s1 <= '0;
      r_addr_s2 <= '0;
      r_data_s1 <= '0;
      r_data_s2 <= '0;
    end else begin
      r_ce_sync <= {r_ce_sync[0], ~eb_ce_n[CE_INDEX]};
      r_oe_sync <= {r_oe_sync[0], ~eb_oe_n};
      r_we_sync <= {r_we_sync[0], ~eb_we_n};
      r_addr_s1 <= eb_address[ADDR_BITS+1:2];
      r_addr_s2 <= r_addr_s1;
      r_data_s1 <= eb_data_in;
      r_data_s2 <= r_data_s1;
    end
  end

  assign w_bus_rdata = (r_addr_s2 == '0) ? ID_VALUE : r_bank[r_addr_s2];

  assign w_commit = (r_state == ST_WRITE) && !w_s_oe && (!w_s_we || !w_s_ce);

  assign w_err_event = ((r_state == ST_IDLE)  && w_s_ce && w_s_oe && w_s_we) ||
                       ((r_state == ST_READ)  && w_s_we) ||
                       ((r_state == ST_WRITE) && w_s_oe);

  always_ff @(posedge int_logic_drm_clock_buffered or posedge system_reset) begin
    if (system_reset) begin
      r_state      <= ST_IDLE;
      r_pend_addr  <= '0;
      r_pend_data  <= '0;
      r_data_out   <= '0;
      r_data_oe    <= 1'b0;
      r_wr_pulse   <= 1'b0;
      r_wr_address <= '0;
      r_wr_data    <= '0;
    end else begin
      r_wr_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_s_ce && w_s_oe && w_s_we) begin
            r_state <= ST_ERROR;
          end else if (w_s_ce && w_s_oe) begin
            r_state    <= ST_READ;
            r_data_oe  <= 1'b1;
            r_data_out <= w_bus_rdata;
          end else if (w_s_ce && w_s_we) begin
            r_state     <= ST_WRITE;
            r_pend_addr <= r_addr_s2;
            r_pend_data <= r_data_s2;
          end
        end
        ST_READ: begin
          if (w_s_we) begin
            r_state   <= ST_ERROR;
            r_data_oe <= 1'b0;
          end else if (!w_s_ce || !w_s_oe) begin
            r_state   <= ST_IDLE;
            r_data_oe <= 1'b0;
          end else begin
            r_data_out <= w_bus_rdata;
          end
        end
        ST_WRITE: begin
          if (w_s_oe) begin
            r_state <= ST_ERROR;
          end else if (w_commit) begin
            r_state      <= ST_IDLE;
            r_wr_pulse   <= 1'b1;
            r_wr_address <= r_pend_addr;
            r_wr_data    <= r_pend_data;
          end else begin
            r_pend_addr <= r_addr_s2;
            r_pend_data <= r_data_s2;
          end
        end
        ST_ERROR: begin
          r_data_oe <= 1'b0;
          if (!w_s_oe && !w_s_we) r_state <= ST_IDLE;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_data_oe <= 1'b0;
        end
      endcase
    end
  end

  // Word 0 is the read-only ID, so its storage is never written.
  always_ff @(posedge int_logic_drm_clock_buffered or posedge system_reset) begin
    if (system_reset) begin
      for (int i = 0; i < WORDS; i++) r_bank[i] <= '0;
    end else if (w_commit && (r_pend_addr != '0)) begin
      r_bank[r_pend_addr] <= r_pend_data;
    end
  end

  always_ff @(posedge int_logic_drm_clock_buffered or posedge system_reset) begin
    if (system_reset) begin
      r_perr <= '0;
    end else if (w_err_event && (r_perr != 8'hFF)) begin
      r_perr <= r_perr + 8'd1;
    end
  end

  assign eb_data_out     = r_data_out;
  assign eb_data_oe      = r_data_oe;
  assign int_read_data   = r_bank[int_read_address];
  assign wr_pulse        = r_wr_pulse;
  assign wr_address      = r_wr_address;
  assign wr_data         = r_wr_data;
  assign protocol_errors = r_perr;

endmodule

// File: tb/tb_ext_bus_target.sv
// Scoreboard bench for ext_bus_target: expected writes/reads are queued at
// drive time and consumed when the DUT strobes wr_pulse or drives read data.
module tb_ext_bus_target;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  eb_ce_n;
  logic        eb_oe_n;
  logic        eb_we_n;
  logic [23:0] eb_address;
  logic [31:0] eb_data_in;
  logic [31:0] eb_data_out;
  logic        eb_data_oe;
  logic [3:0]  int_read_address;
  logic [31:0] int_read_data;
  logic        wr_pulse;
  logic [3:0]  wr_address;
  logic [31:0] wr_data;
  logic [7:0]  protocol_errors;

  localparam logic [3:0]  CE_SEL  = 4'b1101;
  localparam logic [3:0]  CE_OTH  = 4'b1011;
  localparam logic [31:0] ID_EXP  = 32'h6769_7001;

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         wr_q[$];
  wr_t         wr_e;
  logic [31:0] rd_q[$];
  logic [31:0] m_bank [16];
  int          total = 0;
  int          bad   = 0;
  int          perr_exp;

  always #5 clk = ~clk;

  ext_bus_target dut (
    .int_logic_drm_clock_buffered(clk),
    .system_reset(rst),
    .eb_ce_n(eb_ce_n),
    .eb_oe_n(eb_oe_n),
    .eb_we_n(eb_we_n),
    .eb_address(eb_address),
    .eb_data_in(eb_data_in),
    .eb_data_out(eb_data_out),
    .eb_data_oe(eb_data_oe),
    .int_read_address(int_read_address),
    .int_read_data(int_read_data),
    .wr_pulse(wr_pulse),
    .wr_address(wr_address),
    .wr_data(wr_data),
    .protocol_errors(protocol_errors)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (wr_pulse === 1'b1) begin
      if (wr_q.size() == 0) begin
        chk("wr_unexpected", {31'b0, wr_pulse}, 32'd0);
      end else begin
        wr_e = wr_q.pop_front();
        chk("wr_address", {28'b0, wr_address}, {28'b0, wr_e.a});
        chk("wr_data", wr_data, wr_e.d);
      end
    end
  end

  task automatic bus_read(input logic [3:0] word, input logic [31:0] exp);
    @(negedge clk);
    eb_address = {18'b0, word, 2'b00};
    eb_ce_n    = CE_SEL;
    eb_oe_n    = 1'b0;
    rd_q.push_back(exp);
    repeat (2) @(negedge clk);
    chk("rd_oe_early", {31'b0, eb_data_oe}, 32'd0);
    @(negedge clk);
    chk("rd_oe_rise", {31'b0, eb_data_oe}, 32'd1);
    @(negedge clk);
    chk("rd_data", eb_data_out, rd_q.pop_front());
    repeat (2) @(negedge clk);
    eb_oe_n = 1'b1;
    eb_ce_n = 4'hF;
    repeat (2) @(negedge clk);
    chk("rd_oe_hold", {31'b0, eb_data_oe}, 32'd1);
    @(negedge clk);
    chk("rd_oe_fall", {31'b0, eb_data_oe}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic bus_write(input logic [3:0] ce, input logic [3:0] word, input logic [31:0] d);
    logic expect_pulse;
    expect_pulse = (ce == CE_SEL);
    @(negedge clk);
    eb_address = {18'b0, word, 2'b00};
    eb_data_in = d;
    eb_ce_n    = ce;
    eb_we_n    = 1'b0;
    if (expect_pulse) begin
      wr_q.push_back('{a: word, d: d});
      if (word != 4'd0) m_bank[word] = d;
    end
    repeat (4) @(negedge clk);
    eb_we_n = 1'b1;
    eb_ce_n = 4'hF;
    repeat (2) @(negedge clk);
    chk("wr_pulse_early", {31'b0, wr_pulse}, 32'd0);
    @(negedge clk);
    chk("wr_pulse_edge", {31'b0, wr_pulse}, {31'b0, expect_pulse});
    @(negedge clk);
    chk("wr_pulse_width", {31'b0, wr_pulse}, 32'd0);
    eb_data_in = 32'h0;
    repeat (2) @(negedge clk);
  endtask

  task automatic sweep_bank(input string tag);
    for (int i = 0; i < 16; i++) begin
      int_read_address = i[3:0];
      #1;
      chk(tag, int_read_data, m_bank[i]);
    end
  endtask

  initial begin
    rst              = 1'b1;
    eb_ce_n          = 4'hF;
    eb_oe_n          = 1'b1;
    eb_we_n          = 1'b1;
    eb_address       = '0;
    eb_data_in       = '0;
    int_read_address = '0;
    perr_exp         = 0;
    for (int i = 0; i < 16; i++) m_bank[i] = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_oe", {31'b0, eb_data_oe}, 32'd0);
    chk("rst_dout", eb_data_out, 32'd0);
    chk("rst_pulse", {31'b0, wr_pulse}, 32'd0);
    chk("rst_waddr", {28'b0, wr_address}, 32'd0);
    chk("rst_wdata", wr_data, 32'd0);
    chk("rst_perr", {24'b0, protocol_errors}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    bus_read(4'd0, ID_EXP);

    bus_write(CE_SEL, 4'd3, 32'hDEAD_BEEF);
    bus_read(4'd3, 32'hDEAD_BEEF);
    int_read_address = 4'd3;
    #1;
    chk("int_rd_w3", int_read_data, 32'hDEAD_BEEF);

    bus_write(CE_SEL, 4'd0, 32'h1234_5678);
    bus_read(4'd0, ID_EXP);

    bus_write(CE_SEL, 4'd5, $urandom());
    bus_write(CE_SEL, 4'd15, $urandom());
    bus_read(4'd5, m_bank[5]);
    bus_read(4'd15, m_bank[15]);

    // Strobes on a foreign chip select must not disturb anything.
    bus_write(CE_OTH, 4'd3, 32'hBAD0_0BAD);
    @(negedge clk);
    eb_address = {18'b0, 4'd3, 2'b00};
    eb_ce_n    = CE_OTH;
    eb_oe_n    = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("othce_oe", {31'b0, eb_data_oe}, 32'd0);
    end
    eb_oe_n = 1'b1;
    eb_ce_n = 4'hF;
    repeat (4) @(negedge clk);
    sweep_bank("bank_after_writes");

    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      eb_ce_n    = CE_SEL;
      eb_oe_n    = 1'b0;
      eb_we_n    = 1'b0;
      eb_data_in = 32'hFFFF_0000;
      perr_exp   = (perr_exp == 255) ? 255 : perr_exp + 1;
      repeat (4) @(negedge clk);
      chk("err_oe", {31'b0, eb_data_oe}, 32'd0);
      chk("err_count", {24'b0, protocol_errors}, perr_exp);
      eb_ce_n = 4'hF;
      eb_oe_n = 1'b1;
      eb_we_n = 1'b1;
      repeat (4) @(negedge clk);
    end
    chk("err_sat", {24'b0, protocol_errors}, 32'd255);
    sweep_bank("bank_after_errors");

    // Reset in the middle of a read.
    @(negedge clk);
    eb_address = {18'b0, 4'd3, 2'b00};
    eb_ce_n    = CE_SEL;
    eb_oe_n    = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_oe", {31'b0, eb_data_oe}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_read_oe", {31'b0, eb_data_oe}, 32'd0);
    chk("rst_read_dout", eb_data_out, 32'd0);
    eb_oe_n = 1'b1;
    eb_ce_n = 4'hF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) m_bank[i] = 32'h0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a write: the pending word is dropped.
    @(negedge clk);
    eb_address = {18'b0, 4'd7, 2'b00};
    eb_data_in = 32'hCAFE_F00D;
    eb_ce_n    = CE_SEL;
    eb_we_n    = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_write_oe", {31'b0, eb_data_oe}, 32'd0);
    eb_we_n = 1'b1;
    eb_ce_n = 4'hF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    sweep_bank("bank_after_reset");
    chk("perr_after_reset", {24'b0, protocol_errors}, 32'd0);
    chk("wr_q_drained", wr_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
